// File: rtl/sipo_deser.sv
// ============================================================================
// Module  : sipo_deser
// Brief   : MSB-first serial-in parallel-out deserializer with a valid/ready
//           output register and a sticky overrun flag. Define SIPO_PARITY_EN
//           to expect a trailing even-parity bit per frame (adds parity_err).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       si,
  input  logic                       si_valid,
  input  logic                       sync,
  output logic [WIDTH-1:0]           po,
  output logic                       po_valid,
  input  logic                       po_ready,
  output logic                       overrun,
`ifdef SIPO_PARITY_EN
  output logic                       parity_err,
`endif
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int c_CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int c_FRAME = WIDTH + 1;
  localparam int c_SHW   = WIDTH;
`else
  localparam int c_FRAME = WIDTH;
  localparam int c_SHW   = WIDTH - 1;
`endif
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_FRAME - 1);

  localparam logic [0:0] c_S_EMPTY = 1'b0;
  localparam logic [0:0] c_S_FULL  = 1'b1;

  logic [c_SHW-1:0] r_sh;
  logic [c_CW-1:0]  r_cnt;
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_po;
  logic             r_ov;
  logic             w_done;
  logic             w_load;
  logic             w_ovr_set;
  logic [WIDTH-1:0] w_word;

  // The shift register holds only the bits that precede the final one, so the
  // completing bit is spliced in directly from si.
  assign w_done = si_valid && !sync && (r_cnt == c_LAST);

`ifdef SIPO_PARITY_EN
  logic r_perr;
  logic w_perr;
  assign w_word     = r_sh;
  assign w_perr     = ^{r_sh, si};
  assign parity_err = r_perr;
`else
  assign w_word = {r_sh, si};
`endif

  // Bit collector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (sync) begin
      r_sh  <= si_valid ? c_SHW'(si) : '0;
      r_cnt <= si_valid ? c_CW'(1) : '0;
    end else if (si_valid) begin
      r_sh  <= c_SHW'({r_sh, si});
      r_cnt <= w_done ? '0 : r_cnt + c_CW'(1);
    end
  end

  // Output FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_EMPTY: if (w_done) w_state_nxt = c_S_FULL;
      c_S_FULL:  if (po_ready && !w_done) w_state_nxt = c_S_EMPTY;
      default:   w_state_nxt = c_S_EMPTY;
    endcase
  end

  // Output FSM: actions. A word completing into a held, unaccepted slot is lost.
  always_comb begin
    w_load    = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      c_S_EMPTY: w_load = w_done;
      c_S_FULL: begin
        w_load    = w_done && po_ready;
        w_ovr_set = w_done && !po_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_po <= '0;
      r_ov <= 1'b0;
    end else begin
      if (w_load)    r_po <= w_word;
      if (w_ovr_set) r_ov <= 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= w_perr;
    end
  end
`endif

  assign po       = r_po;
  assign po_valid = (r_state == c_S_FULL);
  assign overrun  = r_ov;
  assign bit_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deser.sv
// ============================================================================
// Module  : tb_sipo_deser
// Brief   : Directed vector table plus randomized traffic against a
//           bit-queue reference model for sipo_deser (WIDTH=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_deser;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int c_FRAME = W + 1;
`else
  localparam int c_FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst, si, si_valid, sync, po_ready;
  logic [W-1:0] po;
  logic         po_valid, overrun;
  logic [2:0]   bit_cnt;
`ifdef SIPO_PARITY_EN
  logic         parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  sipo_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .si_valid   (si_valid),
    .sync       (sync),
    .po         (po),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .overrun    (overrun),
`ifdef SIPO_PARITY_EN
    .parity_err (parity_err),
`endif
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, si, sv, sync, rdy;
    logic [3:0] po;
    logic       pv, ov;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, v, y, rd, input logic [3:0] p,
                     input logic pv, ov, input logic [2:0] c);
    vec_t e;
    e.rst = r; e.si = s; e.sv = v; e.sync = y; e.rdy = rd;
    e.po = p; e.pv = pv; e.ov = ov; e.cnt = c;
    tbl.push_back(e);
  endtask

  task automatic step(input logic r, s, v, y, rd);
    rst = r; si = s; si_valid = v; sync = y; po_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ep,
                       input logic epv, eov, input logic [2:0] ec);
    n_vec++;
    if (po !== ep || po_valid !== epv || overrun !== eov || bit_cnt !== ec) begin
      n_err++;
      $display("FAIL %s: got po=%h pv=%b ov=%b cnt=%0d, want po=%h pv=%b ov=%b cnt=%0d",
               name, po, po_valid, overrun, bit_cnt, ep, epv, eov, ec);
    end
  endtask

  // Reference model: bits are queued as they arrive; a full queue forms a word.
  logic         m_q[$];
  logic [W-1:0] m_po;
  logic         m_pv, m_ov, m_perr;

  task automatic model(input logic r, s, v, y, rd);
    bit done = 0;
    int word = 0;
    int ones = 0;
    if (r) begin
      m_q.delete(); m_po = '0; m_pv = 0; m_ov = 0; m_perr = 0;
      return;
    end
    if (y) m_q.delete();
    if (v) m_q.push_back(s);
    if (m_q.size() == c_FRAME) begin
      done = 1;
      for (int i = 0; i < c_FRAME; i++) begin
        if (i < W) word = word * 2 + int'(m_q[i]);
        ones += int'(m_q[i]);
      end
      m_q.delete();
    end
    if (m_pv && rd) m_pv = 0;
    if (done) begin
      if (m_pv) m_ov = 1;
      else begin
        m_po = W'(word); m_pv = 1; m_perr = ones[0];
      end
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0);

`ifndef SIPO_PARITY_EN
    // reset, basic word 1011
    add(1,0,0,0,1, 4'h0,0,0,0); add(1,0,0,0,1, 4'h0,0,0,0);
    add(0,1,1,0,1, 4'h0,0,0,1); add(0,0,1,0,1, 4'h0,0,0,2);
    add(0,1,1,0,1, 4'h0,0,0,3); add(0,1,1,0,1, 4'hB,1,0,0);
    add(0,0,0,0,1, 4'hB,0,0,0);
    // gapped 0110
    add(0,0,1,0,1, 4'hB,0,0,1); add(0,0,0,0,1, 4'hB,0,0,1);
    add(0,1,1,0,1, 4'hB,0,0,2); add(0,0,0,0,1, 4'hB,0,0,2);
    add(0,1,1,0,1, 4'hB,0,0,3); add(0,0,0,0,1, 4'hB,0,0,3);
    add(0,0,1,0,1, 4'h6,1,0,0); add(0,0,0,0,1, 4'h6,0,0,0);
    // backpressure: A held, 5 dropped
    add(0,1,1,0,0, 4'h6,0,0,1); add(0,0,1,0,0, 4'h6,0,0,2);
    add(0,1,1,0,0, 4'h6,0,0,3); add(0,0,1,0,0, 4'hA,1,0,0);
    add(0,0,1,0,0, 4'hA,1,0,1); add(0,1,1,0,0, 4'hA,1,0,2);
    add(0,0,1,0,0, 4'hA,1,0,3); add(0,1,1,0,0, 4'hA,1,1,0);
    add(0,0,0,0,0, 4'hA,1,1,0); add(0,0,0,0,1, 4'hA,0,1,0);
    // accept and complete on the same edge
    add(1,0,0,0,0, 4'h0,0,0,0);
    add(0,0,1,0,0, 4'h0,0,0,1); add(0,0,1,0,0, 4'h0,0,0,2);
    add(0,1,1,0,0, 4'h0,0,0,3); add(0,1,1,0,0, 4'h3,1,0,0);
    add(0,1,1,0,0, 4'h3,1,0,1); add(0,1,1,0,0, 4'h3,1,0,2);
    add(0,0,1,0,0, 4'h3,1,0,3); add(0,0,1,0,1, 4'hC,1,0,0);
    add(0,0,0,0,1, 4'hC,0,0,0);
    // sync mid-word with a bit, then sync without a bit over a held word
    add(0,1,1,0,1, 4'hC,0,0,1); add(0,1,1,0,1, 4'hC,0,0,2);
    add(0,0,1,1,1, 4'hC,0,0,1); add(0,1,1,0,1, 4'hC,0,0,2);
    add(0,0,1,0,1, 4'hC,0,0,3); add(0,1,1,0,1, 4'h5,1,0,0);
    add(0,1,1,0,0, 4'h5,1,0,1); add(0,0,0,1,0, 4'h5,1,0,0);
    add(0,0,0,0,1, 4'h5,0,0,0);
    // reset mid-word with a pending word and overrun set
    add(0,1,1,0,0, 4'h5,0,0,1); add(0,1,1,0,0, 4'h5,0,0,2);
    add(0,1,1,0,0, 4'h5,0,0,3); add(0,1,1,0,0, 4'hF,1,0,0);
    add(0,0,1,0,0, 4'hF,1,0,1); add(0,0,1,0,0, 4'hF,1,0,2);
    add(0,0,1,0,0, 4'hF,1,0,3); add(0,0,1,0,0, 4'hF,1,1,0);
    add(0,1,1,0,0, 4'hF,1,1,1); add(0,1,1,0,0, 4'hF,1,1,2);
    add(1,0,0,0,0, 4'h0,0,0,0); add(0,1,1,0,0, 4'h0,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].si, tbl[i].sv, tbl[i].sync, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].po, tbl[i].pv, tbl[i].ov, tbl[i].cnt);
    end
`else
    // parity: 0111+1 is good, 0111+0 is bad
    begin
      logic [4:0] f_good = 5'b01111;
      logic [4:0] f_bad  = 5'b01110;
      step(1, 0, 0, 0, 1);
      check("par_rst", 4'h0, 0, 0, 0);
      for (int b = 4; b >= 0; b--) step(0, f_good[b], 1, 0, 1);
      check("par_word1", 4'h7, 1, 0, 0);
      n_vec++;
      if (parity_err !== 1'b0) begin
        n_err++;
        $display("FAIL par_err1: got %b want 0", parity_err);
      end
      for (int b = 4; b >= 0; b--) step(0, f_bad[b], 1, 0, 1);
      check("par_word2", 4'h7, 1, 0, 0);
      n_vec++;
      if (parity_err !== 1'b1) begin
        n_err++;
        $display("FAIL par_err2: got %b want 1", parity_err);
      end
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      check("par_midrst", 4'h0, 0, 0, 0);
      n_vec++;
      if (parity_err !== 1'b0) begin
        n_err++;
        $display("FAIL par_err_rst: got %b want 0", parity_err);
      end
    end
`endif

    // randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      logic r, s, v, y, rd;
      r  = (c == 0) || ($urandom_range(0, 127) == 0);
      s  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 9) < 7);
      y  = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 1) == 1);
      step(r, s, v, y, rd);
      model(r, s, v, y, rd);
      check($sformatf("rand%0d", c), m_po, m_pv, m_ov, 3'(m_q.size()));
`ifdef SIPO_PARITY_EN
      if (m_pv || r) begin
        n_vec++;
        if (parity_err !== m_perr) begin
          n_err++;
          $display("FAIL rand_par%0d: got %b want %b", c, parity_err, m_perr);
        end
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
